// File: rtl/seq_mem_pkg.sv
// Shared types and limits for the sequential memory block.
// Write-collision policy enum and maximum read latency.
package seq_mem_pkg;

  typedef enum logic {
    SEQ_MEM_READ_FIRST,
    SEQ_MEM_WRITE_FIRST
  } seq_mem_wmode_e;

  localparam int SEQ_MEM_MAX_READ_LATENCY = 4;

endpackage

// File: rtl/seq_mem_rd_pipe.sv
// Read-data delay line: DEPTH stages of valid/data.
// Valid bits clear asynchronously; data is never reset.
module seq_mem_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_thru
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, reset};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_dly
    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld <= '0;
      end else begin
        vld[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        dat[i] <= dat[i-1];
      end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
  end

endmodule

// File: rtl/seq_mem_d1_pipe.sv
// Byte-masked synchronous memory with a pipelined read port,
// selectable collision policy and a sticky out-of-bounds flag.
module seq_mem_d1_pipe
  import seq_mem_pkg::*;
#(
  parameter int             WIDTH        = 32,
  parameter int             SIZE         = 16,
  parameter int             IDX_SIZE     = 4,
  parameter int             READ_LATENCY = 1,
  parameter seq_mem_wmode_e WRITE_MODE   = SEQ_MEM_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_SIZE-1:0]   read_addr0,
  input  logic                  read_en,
  output logic [WIDTH-1:0]      out,
  output logic                  read_done,
  input  logic [IDX_SIZE-1:0]   write_addr0,
  input  logic [WIDTH-1:0]      in,
  input  logic [WIDTH/8-1:0]    write_mask,
  input  logic                  write_en,
  output logic                  write_done,
  output logic                  oob_error
);

  if (WIDTH < 8 || WIDTH % 8 != 0) begin : g_bad_width
    $error("seq_mem_d1_pipe: WIDTH must be a positive multiple of 8");
  end
  if (READ_LATENCY < 1 ||
      READ_LATENCY > SEQ_MEM_MAX_READ_LATENCY) begin : g_bad_lat
    $error("seq_mem_d1_pipe: READ_LATENCY out of range");
  end
  if (SIZE < 1 || IDX_SIZE < 1 ||
      (2 ** IDX_SIZE) < SIZE) begin : g_bad_idx
    $error("seq_mem_d1_pipe: IDX_SIZE too small for SIZE");
  end

  localparam int NB = WIDTH / 8;
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_SIZE:0] SIZE_L = (IDX_SIZE + 1)'(SIZE);

  logic [WIDTH-1:0] mem [SIZE];

  logic             wr_ok, rd_ok;
  logic             wr_go, rd_go, hit;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] wr_old, wr_word, rd_word;
  logic             p_valid;
  logic [WIDTH-1:0] p_data;

  assign wr_ok  = {1'b0, write_addr0} < SIZE_L;
  assign rd_ok  = {1'b0, read_addr0} < SIZE_L;
  assign wr_go  = write_en & ~reset;
  assign rd_go  = read_en & ~reset;
  assign wr_idx = write_addr0[AW-1:0];
  assign rd_idx = read_addr0[AW-1:0];
  assign hit    = wr_go & wr_ok & rd_ok &
                  (write_addr0 == read_addr0);

  // Masked merge is built once and shared by the array
  // write and the write-first bypass.
  always_comb begin
    wr_old  = mem[wr_idx];
    wr_word = wr_old;
    for (int b = 0; b < NB; b++) begin
      if (write_mask[b]) wr_word[8*b +: 8] = in[8*b +: 8];
    end
    rd_word = rd_ok ? mem[rd_idx] : '0;
    if (WRITE_MODE == SEQ_MEM_WRITE_FIRST && hit) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go && wr_ok) mem[wr_idx] <= wr_word;
  end

  seq_mem_rd_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (READ_LATENCY - 1)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_go),
    .in_data   (rd_word),
    .out_valid (p_valid),
    .out_data  (p_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      read_done  <= 1'b0;
      write_done <= 1'b0;
      oob_error  <= 1'b0;
    end else begin
      read_done  <= p_valid;
      write_done <= write_en;
      if (p_valid) out <= p_data;
      if ((read_en && !rd_ok) || (write_en && !wr_ok)) begin
        oob_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mem_d1_pipe.sv
// Directed bench: READ_LATENCY=3, SIZE=16, one instance per
// collision policy driven from the same stimulus.
module tb_seq_mem_d1_pipe;
  import seq_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_addr0, write_addr0;
  logic        read_en, write_en;
  logic [31:0] in;
  logic [3:0]  write_mask;

  logic [31:0] rf_out, wf_out;
  logic        rf_rd, wf_rd, rf_wd, wf_wd, rf_oob, wf_oob;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_mem_d1_pipe #(
    .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .READ_LATENCY(3),
    .WRITE_MODE(SEQ_MEM_READ_FIRST)
  ) u_rf (
    .clk(clk), .reset(reset),
    .read_addr0(read_addr0), .read_en(read_en),
    .out(rf_out), .read_done(rf_rd),
    .write_addr0(write_addr0), .in(in),
    .write_mask(write_mask), .write_en(write_en),
    .write_done(rf_wd), .oob_error(rf_oob)
  );

  seq_mem_d1_pipe #(
    .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .READ_LATENCY(3),
    .WRITE_MODE(SEQ_MEM_WRITE_FIRST)
  ) u_wf (
    .clk(clk), .reset(reset),
    .read_addr0(read_addr0), .read_en(read_en),
    .out(wf_out), .read_done(wf_rd),
    .write_addr0(write_addr0), .in(in),
    .write_mask(write_mask), .write_en(write_en),
    .write_done(wf_wd), .oob_error(wf_oob)
  );

  typedef struct {
    logic        rd;
    logic [4:0]  ra;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        e_rd;
    logic [31:0] e_rf;
    logic [31:0] e_wf;
    logic        e_wd;
    logic        e_oob;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic idle();
    read_en = 1'b0; write_en = 1'b0;
    read_addr0 = '0; write_addr0 = '0;
    in = '0; write_mask = '0;
  endtask

  initial begin
    // Expected outputs are those seen in the row's cycle,
    // before that row's inputs are clocked in.
    tv[0]  = '{1'b0, 5'd0,  1'b1, 5'd5, 32'hDEADBEEF, 4'hF,
               1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 5'd0,  1'b1, 5'd2, 32'h11223344, 4'hF,
               1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 5'd5,  1'b1, 5'd7, 32'h00000000, 4'hF,
               1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 5'd0,  1'b1, 5'd2, 32'hAABBCCDD, 4'h2,
               1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 5'd2,  1'b1, 5'd0, 32'hA0A0A0A0, 4'hF,
               1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 5'd0,  1'b1, 5'd1, 32'hA1A1A1A1, 4'hF,
               1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 5'd0,  1'b1, 5'd3, 32'hA3A3A3A3, 4'hF,
               1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 5'd7,  1'b1, 5'd7, 32'h00000055, 4'h1,
               1'b1, 32'h1122CC44, 32'h1122CC44, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 5'd0,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b0, 32'h1122CC44, 32'h1122CC44, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 5'd1,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b0, 32'h1122CC44, 32'h1122CC44, 1'b0, 1'b0};
    tv[10] = '{1'b1, 5'd2,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'h00000000, 32'h00000055, 1'b0, 1'b0};
    tv[11] = '{1'b1, 5'd3,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, 1'b0};
    tv[12] = '{1'b1, 5'd20, 1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'hA1A1A1A1, 32'hA1A1A1A1, 1'b0, 1'b0};
    tv[13] = '{1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'h1122CC44, 32'h1122CC44, 1'b0, 1'b1};
    tv[14] = '{1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'hA3A3A3A3, 32'hA3A3A3A3, 1'b0, 1'b1};
    tv[15] = '{1'b0, 5'd0,  1'b0, 5'd0, 32'h0, 4'h0,
               1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1};

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_out", rf_out, 32'h0);
    chk("rst_rd", {31'b0, rf_rd}, 32'h0);
    chk("rst_wd", {31'b0, rf_wd}, 32'h0);
    chk("rst_oob", {31'b0, rf_oob}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_rf_rd", i), {31'b0, rf_rd},
          {31'b0, tv[i].e_rd});
      chk($sformatf("v%0d_wf_rd", i), {31'b0, wf_rd},
          {31'b0, tv[i].e_rd});
      chk($sformatf("v%0d_rf_out", i), rf_out, tv[i].e_rf);
      chk($sformatf("v%0d_wf_out", i), wf_out, tv[i].e_wf);
      chk($sformatf("v%0d_wd", i), {31'b0, rf_wd},
          {31'b0, tv[i].e_wd});
      chk($sformatf("v%0d_oob", i), {31'b0, wf_oob},
          {31'b0, tv[i].e_oob});
      read_en     = tv[i].rd;
      read_addr0  = tv[i].ra;
      write_en    = tv[i].wr;
      write_addr0 = tv[i].wa;
      in          = tv[i].wd;
      write_mask  = tv[i].wm;
    end

    // Read in flight, then reset one cycle later.
    @(negedge clk);
    idle();
    read_en = 1'b1; read_addr0 = 5'd5;
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    chk("ar_out", rf_out, 32'h0);
    chk("ar_rd", {31'b0, rf_rd}, 32'h0);
    chk("ar_oob", {31'b0, rf_oob}, 32'h0);
    chk("ar_wf_oob", {31'b0, wf_oob}, 32'h0);
    // Requests during reset must be ignored.
    read_en = 1'b1; read_addr0 = 5'd20;
    write_en = 1'b1; write_addr0 = 5'd5;
    in = 32'h12345678; write_mask = 4'hF;
    repeat (2) @(negedge clk);
    chk("in_rst_wd", {31'b0, rf_wd}, 32'h0);
    reset = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_rd%0d", i), {31'b0, rf_rd}, 32'h0);
      chk($sformatf("post_rst_out%0d", i), rf_out, 32'h0);
      chk($sformatf("post_rst_oob%0d", i), {31'b0, rf_oob}, 32'h0);
    end

    // Out-of-bounds write aliasing addr 5 must not touch memory.
    write_en = 1'b1; write_addr0 = 5'd21;
    in = 32'hFFFFFFFF; write_mask = 4'hF;
    @(negedge clk);
    idle();
    chk("oobw_wd", {31'b0, rf_wd}, 32'h1);
    chk("oobw_oob", {31'b0, rf_oob}, 32'h1);
    read_en = 1'b1; read_addr0 = 5'd5;
    @(negedge clk);
    idle();
    chk("rd5_c1", {31'b0, rf_rd}, 32'h0);
    @(negedge clk);
    chk("rd5_c2", {31'b0, rf_rd}, 32'h0);
    @(negedge clk);
    chk("rd5_done", {31'b0, rf_rd}, 32'h1);
    chk("rd5_rf", rf_out, 32'hDEADBEEF);
    chk("rd5_wf", wf_out, 32'hDEADBEEF);
    chk("oob_sticky", {31'b0, rf_oob}, 32'h1);
    @(negedge clk);
    chk("rd5_pulse", {31'b0, rf_rd}, 32'h0);
    chk("rd5_hold", rf_out, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
